// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-word handshake between a byte producer and uart_tx.
//   tx_input  word to send, sampled by the transmitter only at acceptance
//   new_data  level request to send tx_input, qualified by ready
//   ready     transmitter idle and enabled; the next new_data is accepted
// master = producer side, slave = transmitter side.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_input;
    logic                 new_data;
    logic                 ready;

    modport master (output tx_input, output new_data, input  ready);
    modport slave  (input  tx_input, input  new_data, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: transmit-only UART serializer with an integer baud divider.
// Emits start(0), DATA_BITS data bits LSB first, stop(1); the line idles high.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   enable   1 = operating, 0 = held idle (aborts a frame in flight)
//   bus      uart_tx_if.slave: tx_input / new_data in, ready out
//   tx_wire  registered serial output
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable,
    uart_tx_if.slave bus,
    output logic     tx_wire
);
    localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;
    logic [IDX_W-1:0]     idx_nxt;

    assign bit_done  = (cnt_q == CNT_LAST);
    assign idx_nxt   = idx_q + 1'b1;
    assign bus.ready = (state_q == IDLE) && enable;
    assign tx_wire   = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the value the line carries from the next edge on, so every
    // transition drives the first bit of the state it enters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        if (!enable) begin
            // Abort: back to a clean idle line; the latched word is dead.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    tx_d  = 1'b1;
                    // tx_input is only looked at here, so X/Z on it while
                    // idle never reaches the line.
                    if (bus.new_data) begin
                        shift_d = bus.tx_input;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            idx_d = idx_nxt;
                            tx_d  = shift_q[idx_nxt];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        // One IDLE cycle always follows, so back-to-back
                        // frames have exactly one ready cycle between them.
                        cnt_d   = '0;
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. A short bit period keeps the
// run small; every frame is compared cycle by cycle against the expected
// 10-bit line pattern taken from a scoreboard queue.
module tb_uart_tx;
    localparam int BAUD    = 9600;
    localparam int SYS_CLK = 153600;            // 16 clk per bit
    localparam int CPB     = SYS_CLK / BAUD;

    logic clk, rst_n, enable, tx_wire;
    uart_tx_if #(.DATA_BITS(8)) bus ();

    uart_tx #(.DATA_BITS(8), .BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .tx_wire(tx_wire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // bit i = i-th bit on the line (0 = start)
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered on the negedge of frame cycle 0 (just after the accepting edge);
    // returns on the negedge of the idle cycle following the stop bit.
    task automatic capture(input string name);
        logic [9:0] exp, got;
        logic bad_cyc, bad_rdy;
        bad_cyc = 1'b0;
        bad_rdy = 1'b0;
        got = '0;
        if (sb_q.size() == 0) begin
            check({name, " sb_empty"}, 1'b0, 0, 1);
            return;
        end
        exp = sb_q.pop_front();
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (k == CPB / 2) got[b] = tx_wire;
                if (tx_wire !== exp[b]) bad_cyc = 1'b1;
                if (bus.ready !== 1'b0) bad_rdy = 1'b1;
                @(negedge clk);
            end
        end
        check({name, " frame"}, (got === exp) && !bad_cyc, {22'd0, got}, {22'd0, exp});
        check({name, " busy_ready"}, !bad_rdy, {31'd0, bad_rdy}, 0);
        check({name, " idle_after"}, (bus.ready === 1'b1) && (tx_wire === 1'b1),
              {30'd0, bus.ready, tx_wire}, 32'd3);
    endtask

    task automatic send_frame(input string name, input logic [7:0] data,
                              input logic [9:0] exp, input logic hold);
        @(negedge clk);
        bus.tx_input = data;
        bus.new_data = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        if (!hold) begin
            bus.new_data = 1'b0;
            bus.tx_input = ~data;   // changes after acceptance must be ignored
        end
        capture(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        vecs[0] = '{8'h00, 10'b1000000000};
        vecs[1] = '{8'hA5, 10'b1101001010};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'h3C, 10'b1001111000};

        rst_n = 1'b0;
        enable = 1'b0;
        bus.new_data = 1'b0;
        bus.tx_input = 'x;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_wire === 1'b1, {31'd0, tx_wire}, 1);
        check("rst_ready_dis", bus.ready === 1'b0, {31'd0, bus.ready}, 0);
        enable = 1'b1;
        #1;
        check("rst_ready_en", bus.ready === 1'b1, {31'd0, bus.ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 bit times with X on tx_input.
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int k = 0; k < CPB; k++) begin
                if (tx_wire !== 1'b1 || bus.ready !== 1'b1) bad = 1'b1;
                @(negedge clk);
            end
            check("idle_x", !bad, {31'd0, bad}, 0);
        end

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bits, 1'b0);
            repeat (3) @(negedge clk);
        end

        // Back-to-back: new_data held, one idle cycle between frames.
        send_frame("b2b_1", 8'h55, 10'b1010101010, 1'b1);
        sb_q.push_back(10'b1010101010);
        @(negedge clk);
        bus.new_data = 1'b0;
        capture("b2b_2");
        @(negedge clk);
        check("b2b_no_third", tx_wire === 1'b1 && bus.ready === 1'b1,
              {30'd0, bus.ready, tx_wire}, 32'd3);

        // Enable dropped mid-data of 8'hFF.
        @(negedge clk);
        bus.tx_input = 8'hFF;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
        repeat (3 * CPB + 3) @(negedge clk);
        check("en_mid_busy", bus.ready === 1'b0, {31'd0, bus.ready}, 0);
        enable = 1'b0;
        @(negedge clk);
        check("en_abort", tx_wire === 1'b1 && bus.ready === 1'b0,
              {30'd0, bus.ready, tx_wire}, 32'd1);
        repeat (5) @(negedge clk);
        check("en_hold_idle", tx_wire === 1'b1, {31'd0, tx_wire}, 1);
        enable = 1'b1;
        #1;
        check("en_reenable", bus.ready === 1'b1 && tx_wire === 1'b1,
              {30'd0, bus.ready, tx_wire}, 32'd3);
        send_frame("after_en", 8'h01, 10'b1000000010, 1'b0);

        // Asynchronous reset mid-frame of 8'h00.
        @(negedge clk);
        bus.tx_input = 8'h00;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("rst_mid_low", tx_wire === 1'b0, {31'd0, tx_wire}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx_wire === 1'b1, {31'd0, tx_wire}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", bus.ready === 1'b1 && tx_wire === 1'b1,
              {30'd0, bus.ready, tx_wire}, 32'd3);
        send_frame("after_rst", 8'h3C, 10'b1001111000, 1'b0);

        check("sb_drained", sb_q.size() == 0, sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
